// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory slice: latency ceiling, clear-FSM
// states and the read-pipeline entry.
// Word and address widths normally come from architecture.vh. The defaults
// below apply only when that header is not part of the build.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN (zero-fill sweep after reset).
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif

package data_memory_pkg;

   // Deepest read pipeline the block is built for.
   localparam int DMEM_MAX_LATENCY = 4;

   // Post-reset clear sweep states.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } dmem_clr_state_e;

   // One in-flight load. The index is kept at full address width so the
   // completing stage can re-check the range on its own.
   typedef struct packed {
      logic                     valid;
      logic                     in_range;
      logic [`ADDRESS_SIZE-1:0] index;
   } dmem_pipe_entry_t;

endpackage

// File: rtl/dmem_read_pipe.sv
// Fixed-depth shift register of load entries. An entry pushed at posedge N
// appears on entry_o during the cycle after posedge N+LATENCY-1. Reset
// empties every stage, so loads in flight are dropped.
module dmem_read_pipe
   import data_memory_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  dmem_pipe_entry_t entry_i,
   output dmem_pipe_entry_t entry_o
);

   dmem_pipe_entry_t stage_q [LATENCY];

   // Advance every entry by one stage per cycle, or flush on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= entry_i;
         for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign entry_o = stage_q[LATENCY-1];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory that responds on the core's load/store port.
// Loads return through a READ_LATENCY-deep pipeline and are marked by a
// one-cycle read_valid. Out-of-range accesses and read+write collisions
// raise a one-cycle access_error.
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN. When it is defined, a
// sweep writes zero to every word after reset and busy is high during the
// sweep. When it is undefined, busy is tied low and contents survive reset.
// The array is read when a load leaves the pipeline. A store that lands on
// the same word while that load is still in flight (possible only when
// READ_LATENCY > 1) is therefore visible in the returned data.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif

module data_memory
   import data_memory_pkg::*;
#(
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     read,
   input  logic                     write,
   input  logic [`ADDRESS_SIZE-1:0] address,
   input  logic [`DATA_SIZE-1:0]    data_in,
   output logic [`DATA_SIZE-1:0]    data_out,
   output logic                     read_valid,
   output logic                     access_error,
   output logic                     busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [`ADDRESS_SIZE:0] DEPTH_A = (`ADDRESS_SIZE+1)'(DEPTH);

   logic [`DATA_SIZE-1:0] mem_q [DEPTH];

   logic                  in_range;
   logic                  accept;
   logic                  rd_req;
   logic                  wr_req;
   logic                  err_d;
   logic                  busy_w;
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_widx;
   logic [`DATA_SIZE-1:0] mem_wdata;
   logic                  rd_ok;
   logic [IDX_W-1:0]      rd_idx;

   dmem_pipe_entry_t      pipe_in;
   dmem_pipe_entry_t      pipe_out;

   logic [`DATA_SIZE-1:0] data_out_q;
   logic                  read_valid_q;
   logic                  access_error_q;

   // Accesses are taken only outside reset and outside a clear sweep.
   // A read that collides with a write is dropped; the write still goes in.
   assign in_range = ({1'b0, address} < DEPTH_A);
   assign accept   = !reset && !busy_w;
   assign rd_req   = accept && read && !write;
   assign wr_req   = accept && write && in_range;
   assign err_d    = accept && (read || write) && ((read && write) || !in_range);

   assign pipe_in = '{valid: rd_req, in_range: in_range, index: address};

   dmem_read_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_read_pipe (
      .clock   (clock),
      .reset   (reset),
      .entry_i (pipe_in),
      .entry_o (pipe_out)
   );

`ifdef DMEM_CLEAR_ON_RESET_EN
   dmem_clr_state_e  state_q;
   logic [IDX_W-1:0] clr_idx_q;
   logic             busy_q;
   logic             clr_we;

   assign clr_we = (state_q == CLEAR) && !reset;
   assign busy_w = busy_q;

   // Clear sweep: reset (re)starts it at word 0, then one word per cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
            end
            CLEAR: begin
               if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                  state_q   <= IDLE;
                  clr_idx_q <= '0;
                  busy_q    <= 1'b0;
               end else begin
                  clr_idx_q <= clr_idx_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
`else
   assign busy_w = 1'b0;
`endif

   // Single write port, shared by core stores and the clear sweep.
   always_comb begin
      mem_we    = wr_req;
      mem_widx  = address[IDX_W-1:0];
      mem_wdata = data_in;
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_widx  = clr_idx_q;
         mem_wdata = '0;
      end
`endif
   end

   // Storage array; reset leaves it untouched.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   // An out-of-range load completes normally but returns zero.
   assign rd_idx = pipe_out.index[IDX_W-1:0];
   assign rd_ok  = pipe_out.in_range && ({1'b0, pipe_out.index} < DEPTH_A);

   // Load completion and error strobe; data_out holds between loads.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_out_q     <= '0;
         read_valid_q   <= 1'b0;
         access_error_q <= 1'b0;
      end else begin
         read_valid_q   <= pipe_out.valid;
         access_error_q <= err_d;
         if (pipe_out.valid) begin
            data_out_q <= rd_ok ? mem_q[rd_idx] : '0;
         end
      end
   end

   assign data_out     = data_out_q;
   assign read_valid   = read_valid_q;
   assign access_error = access_error_q;
   assign busy         = busy_w;

endmodule
